// File: rtl/pc_exc_unit.sv
// PC register stage with EPC capture and exception-vector fetch sequencer.
// Optional misaligned-target exception (cause 3) enabled by defining PC_ALIGN_CHECK_EN.
module pc_exc_unit #(
  parameter logic [31:0] VEC_BASE = 32'd253,
  parameter int          MEM_LAT  = 2,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic        branch_ne,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [7:0]  mem_byte,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [31:0] exc_addr,
  output logic        exc_addr_valid,
`ifdef PC_ALIGN_CHECK_EN
  output logic [1:0]  exc_cause,
`endif
  output logic        exc_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SAVE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] addr_q, addr_d;
  logic        vld_q, vld_d;
  logic [1:0]  cause_q, cause_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        wen;
  logic        take_exc;
  logic [1:0]  exc_idx;

  always_comb begin
    wen      = pc_write | (pc_write_cond & (zero ^ branch_ne));
    take_exc = exc_opcode | exc_ovf | exc_div0;
    if (exc_opcode)   exc_idx = 2'd0;
    else if (exc_ovf) exc_idx = 2'd1;
    else              exc_idx = 2'd2;
`ifdef PC_ALIGN_CHECK_EN
    // Misaligned write target only raises an exception when nothing else is pending.
    if (!take_exc && wen && (pc_next[1:0] != 2'b00)) begin
      take_exc = 1'b1;
      exc_idx  = 2'd3;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    addr_d  = addr_q;
    vld_d   = vld_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (take_exc) begin
          // Fetch already advanced the PC, so the faulting instruction is one word back.
          epc_d   = pc_q - 32'd4;
          cause_d = exc_idx;
          state_d = S_SAVE;
        end else if (wen) begin
          pc_d = pc_next;
        end
      end
      S_SAVE: begin
        addr_d  = VEC_BASE + {30'd0, cause_q};
        vld_d   = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_LOAD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: begin
        pc_d    = {24'd0, mem_byte};
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      addr_q  <= 32'd0;
      vld_q   <= 1'b0;
      cause_q <= 2'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out         = pc_q;
  assign epc_out        = epc_q;
  assign exc_addr       = addr_q;
  assign exc_addr_valid = vld_q;
  assign exc_busy       = (state_q != S_IDLE);
`ifdef PC_ALIGN_CHECK_EN
  assign exc_cause      = cause_q;
`endif

endmodule
